phy_tx_serializer: RTL

Transmit-side parallel-to-serial converter for the PHY link, running entirely on `clk_32f`. It accepts one WIDTH-bit word per WIDTH clock cycles over a valid/ready handshake and shifts it out MSB first. It fills every unused word slot with the comma/idle word, and sends a mandatory burst of comma words after reset so the receive-side deserializer can align. It is the transmit counterpart of the receive-side clock and deserializer path: words leave at the `clk_4f` word rate, with one bit per `clk_32f` cycle.

---
 rtl/phy_tx_serializer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/phy_tx_serializer.sv
// -----------------------------------------------------------------------------
// phy_tx_serializer
//
// Transmit-side parallel-to-serial converter for the PHY link. One WIDTH-bit
// word is taken per WIDTH-cycle slot over a valid/ready handshake and shifted
// out MSB first, one bit per clk_32f cycle. Slots with no accepted word carry
// IDLE_WORD (comma), and after reset or re-enable SYNC_WORDS comma slots are
// sent before any data is accepted so the far-end deserializer can align.
//
// Ports:
//   clk_32f    in   bit clock (single clock domain)
//   reset_L    in   asynchronous active-low reset
//   enable     in   synchronous enable; low returns to the reset state
//   in_data    in   [WIDTH-1:0] parallel word to transmit
//   in_valid   in   in_data is valid
//   in_ready   out  word consumed at this edge when in_valid is also high
//   data_out   out  serial bit (MSB of shift register)
//   word_start out  high while the MSB of a slot is on data_out
//   sync_done  out  high once the comma burst has been sent (ACTIVE)
// -----------------------------------------------------------------------------
module phy_tx_serializer #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD  = 8'hBC,
  parameter int               SYNC_WORDS = 4
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data_out,
  output logic             word_start,
  output logic             sync_done
);

  localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SYNC_W = (SYNC_WORDS > 0) ? $clog2(SYNC_WORDS + 1) : 1;

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [SYNC_W-1:0] LAST_SYNC = SYNC_W'(SYNC_WORDS - 1);

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [WIDTH-1:0]  shreg_reg, shreg_next;
  logic [SYNC_W-1:0] sync_cnt_reg, sync_cnt_next;
  logic [WIDTH-1:0]  next_word;
  logic [WIDTH-1:0]  shreg_shifted;
  logic              boundary;

  // bit_cnt idles at WIDTH-1 in reset, so the very first enabled edge is a
  // load boundary and the first comma word starts immediately.
  assign boundary = (bit_cnt_reg == LAST_BIT);

  // Shift towards the MSB, filling with zero.
  assign shreg_shifted[0] = 1'b0;
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
    assign shreg_shifted[gi] = shreg_reg[gi-1];
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_reg <= SYNC;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. The last sync slot still loads a comma; the switch to
  // ACTIVE happens on that same edge. ACTIVE has no data-dependent exit.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = SYNC;
    end else if (state_reg == SYNC && boundary && sync_cnt_reg == LAST_SYNC) begin
      state_next = ACTIVE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready   = boundary && (state_reg == ACTIVE) && enable;
    data_out   = shreg_reg[WIDTH-1];
    // Gated by reset_L and enable so it drops as soon as either falls.
    word_start = (bit_cnt_reg == '0) && enable && reset_L;
    sync_done  = (state_reg == ACTIVE);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    next_word     = (state_reg == ACTIVE && in_valid) ? in_data : IDLE_WORD;
    bit_cnt_next  = bit_cnt_reg;
    shreg_next    = shreg_reg;
    sync_cnt_next = sync_cnt_reg;

    if (!enable) begin
      bit_cnt_next  = LAST_BIT;
      shreg_next    = '0;
      sync_cnt_next = '0;
    end else if (boundary) begin
      bit_cnt_next = '0;
      shreg_next   = next_word;
      if (state_reg == SYNC) begin
        sync_cnt_next = sync_cnt_reg + SYNC_W'(1);
      end
    end else begin
      bit_cnt_next = bit_cnt_reg + CNT_W'(1);
      shreg_next   = shreg_shifted;
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt_reg  <= LAST_BIT;
      shreg_reg    <= '0;
      sync_cnt_reg <= '0;
    end else begin
      bit_cnt_reg  <= bit_cnt_next;
      shreg_reg    <= shreg_next;
      sync_cnt_reg <= sync_cnt_next;
    end
  end

endmodule
